// File: rtl/cal_multi.sv
// cal_multi - multi-channel sample calibrator.
//
// For each of N_CH signed W-bit channels: removes a DC offset, scales by a
// gain with SHIFT fractional bits, saturates to +/-CLAMP, and mutes channels
// 0..N_JACK-1 whose jack is unplugged. A single multiplier is shared across
// all channels. A pass takes three cycles per channel (SUB, MUL, SAT) plus
// one OUT cycle, so results appear 3*N_CH+1 clock edges after capture.
//
// Optional build macro:
//   CAL_ROUND_EN  defined: MUL adds 1<<(SHIFT-1) before the shift (round half up).
//                 undefined: plain arithmetic shift (floor). Latency is the same.
//
// Coefficient RAM: 2*N_CH signed words, [2c]=offset, [2c+1]=gain. It is not
// cleared by reset and has no power-up contents in this tree; it is loaded
// through the cal_* write port before the first pass.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sample_clk   frame strobe; a rising edge seen in IDLE starts a pass
//   jack         1 = jack inserted on channel c (sampled in OUT)
//   in_flat      raw samples, channel c = in_flat[c*W +: W]
//   out_flat     calibrated samples, same packing; held between passes
//   out_valid    one-cycle pulse when out_flat updates
//   busy         high from the capturing edge until the OUT edge
//   overrun      sticky; a sample_clk edge arrived while busy
//   cal_we       coefficient write request
//   cal_addr     coefficient index (indexes >= 2*N_CH are ignored)
//   cal_wdata    coefficient value (signed)
//   cal_ready    high in IDLE
//   dbg_state_o  current FSM state (IDLE=0, SUB=1, MUL=2, SAT=3, OUT=4)
//
// Handshake: a coefficient write is accepted on a clock edge where
// cal_we && cal_ready; the requester holds cal_we/cal_addr/cal_wdata
// stable until then. A write and a sample_clk edge in the same IDLE
// cycle both take effect; the pass reads the freshly written value.
module cal_multi #(
    parameter int W      = 16,
    parameter int N_CH   = 8,
    parameter int N_JACK = 4,
    parameter int SHIFT  = 10,
    parameter int CLAMP  = 32000,
    localparam int JW    = (N_JACK < 1) ? 1 : N_JACK,
    localparam int AW    = (N_CH < 2) ? 1 : $clog2(2 * N_CH),
    localparam int CW    = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_clk,
    input  logic [JW-1:0]     jack,
    input  logic [N_CH*W-1:0] in_flat,
    output logic [N_CH*W-1:0] out_flat,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    input  logic              cal_we,
    input  logic [AW-1:0]     cal_addr,
    input  logic [W-1:0]      cal_wdata,
    output logic              cal_ready,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB  = 3'd1,
        S_MUL  = 3'd2,
        S_SAT  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic signed [2*W:0] CLAMP_HI = (2*W+1)'(CLAMP);
    localparam logic signed [2*W:0] CLAMP_LO = -CLAMP_HI;
`ifdef CAL_ROUND_EN
    localparam logic signed [2*W:0] RND      = (2*W+1)'(1) <<< (SHIFT - 1);
`endif

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic                sc_q;
    logic                sc_edge;
    logic signed [W:0]   d_q, d_d;
    logic signed [2*W:0] p_q, p_d;
    logic signed [2*W:0] prod;
    logic signed [W-1:0] sat_r;
    logic signed [W-1:0] samp_q [N_CH];
    logic signed [W-1:0] res_q  [N_CH];
    logic signed [W-1:0] off_q  [N_CH];
    logic signed [W-1:0] gain_q [N_CH];
    logic [N_CH*W-1:0]   out_flat_q, out_flat_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                cap_en, res_we, cal_wr;
    logic [CW-1:0]       wr_ch;
    logic [N_CH-1:0]     jack_ext;

    assign sc_edge  = sample_clk & ~sc_q;
    assign wr_ch    = CW'(cal_addr >> 1);
    // Channels without a jack detect line read as always inserted.
    assign jack_ext = N_CH'({{N_CH{1'b1}}, jack});

    // Operands are sign-extended to the full product width before multiplying.
    assign prod = (2*W+1)'(d_q) * (2*W+1)'(gain_q[ch_q]);

    always_comb begin
        if (p_q > CLAMP_HI) begin
            sat_r = W'(CLAMP);
        end else if (p_q < CLAMP_LO) begin
            sat_r = W'(-CLAMP);
        end else begin
            sat_r = p_q[W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        d_d         = d_q;
        p_d         = p_q;
        out_flat_d  = out_flat_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        cap_en      = 1'b0;
        res_we      = 1'b0;
        cal_wr      = 1'b0;

        // Edges during a pass are dropped; the pass itself is unaffected.
        if (sc_edge && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cal_wr = rst_n && cal_we && (int'(cal_addr) < 2 * N_CH);
                if (sc_edge) begin
                    cap_en  = 1'b1;
                    ch_d    = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                d_d     = (W+1)'(samp_q[ch_q]) - (W+1)'(off_q[ch_q]);
                state_d = S_MUL;
            end
            S_MUL: begin
`ifdef CAL_ROUND_EN
                p_d = (prod + RND) >>> SHIFT;
`else
                p_d = prod >>> SHIFT;
`endif
                state_d = S_SAT;
            end
            S_SAT: begin
                res_we = 1'b1;
                if (ch_q == CW'(N_CH - 1)) begin
                    state_d = S_OUT;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_SUB;
                end
            end
            S_OUT: begin
                for (int c = 0; c < N_CH; c++) begin
                    out_flat_d[c*W +: W] = (c < N_JACK && !jack_ext[c]) ? '0 : res_q[c];
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            sc_q        <= 1'b0;
            out_flat_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            sc_q        <= sample_clk;
            out_flat_q  <= out_flat_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Datapath and coefficient storage need no reset; the FSM gates their use.
    always_ff @(posedge clk) begin
        d_q <= d_d;
        p_q <= p_d;
        if (cap_en) begin
            for (int c = 0; c < N_CH; c++) begin
                samp_q[c] <= in_flat[c*W +: W];
            end
        end
        if (res_we) begin
            res_q[ch_q] <= sat_r;
        end
        if (cal_wr) begin
            if (cal_addr[0]) begin
                gain_q[wr_ch] <= cal_wdata;
            end else begin
                off_q[wr_ch] <= cal_wdata;
            end
        end
    end

    assign out_flat    = out_flat_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign cal_ready   = (state_q == S_IDLE);
    assign dbg_state_o = state_q;

endmodule
